output_conditioner: RTL and testbench

- Transmit-side counterpart of the input conditioner: drives an external pin so that a downstream debouncing receiver always sees clean, resolvable transitions.
- Takes a requested level plus one-shot pulse requests from core logic.
- Guarantees every pin level is held for at least HOLDTIME clocks.
- Reports the pin edges it generates, cycle-aligned with the pin change.

---
 rtl/output_conditioner_if.sv | 31 +++
 rtl/output_conditioner.sv | 157 +++++++++++++++
 tb/tb_output_conditioner.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/output_conditioner_if.sv
// Core-side bundle for output_conditioner: level/pulse requests in, pin drive and status out.
`timescale 1ns/1ps
interface output_conditioner_if;
    logic desired;
    logic pulsereq;
    logic pin;
    logic positiveedge;
    logic negativeedge;
    logic busy;
    logic overrun;

    modport master (
        output desired,
        output pulsereq,
        input  pin,
        input  positiveedge,
        input  negativeedge,
        input  busy,
        input  overrun
    );

    modport slave (
        input  desired,
        input  pulsereq,
        output pin,
        output positiveedge,
        output negativeedge,
        output busy,
        output overrun
    );
endinterface

// File: rtl/output_conditioner.sv
// Pin driver that holds every level for at least HOLDTIME clocks and emits registered edge flags.
// Define OUTCOND_SYNC_EN to add 2-flop synchronizers and a pulsereq edge detector on the inputs.
`timescale 1ns/1ps
module output_conditioner #(
    parameter int counterwidth = 3,
    parameter int HOLDTIME     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    output_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam logic [counterwidth-1:0] CNT_ONE  = counterwidth'(1);
    localparam logic [counterwidth-1:0] CNT_MAX  = '1;
    localparam logic [counterwidth-1:0] HOLD_CNT = counterwidth'(HOLDTIME);

    logic desired_in;
    logic request_in;

`ifdef OUTCOND_SYNC_EN
    logic [1:0] des_sync_q, des_sync_d;
    logic [1:0] req_sync_q, req_sync_d;
    logic       req_prev_q, req_prev_d;

    always_comb begin
        des_sync_d = {des_sync_q[0], bus.desired};
        req_sync_d = {req_sync_q[0], bus.pulsereq};
        req_prev_d = req_sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            des_sync_q <= 2'b00;
            req_sync_q <= 2'b00;
            req_prev_q <= 1'b0;
        end else begin
            des_sync_q <= des_sync_d;
            req_sync_q <= req_sync_d;
            req_prev_q <= req_prev_d;
        end
    end

    // A held-high request counts once: only its synchronized rising edge is a request.
    assign desired_in = des_sync_q[1];
    assign request_in = req_sync_q[1] & ~req_prev_q;
`else
    assign desired_in = bus.desired;
    assign request_in = bus.pulsereq;
`endif

    state_t                  state_q, state_d;
    logic [counterwidth-1:0] counter_q, counter_d;
    logic                    pending_q, pending_d;
    logic                    pin_q, pin_d;
    logic                    posedge_q, posedge_d;
    logic                    negedge_q, negedge_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic [counterwidth-1:0] counter_inc;

    assign counter_inc = (counter_q == CNT_MAX) ? counter_q : counter_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        pending_d = pending_q;
        pin_d     = pin_q;
        overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (desired_in != pin_q) begin
                    // Level change beats a simultaneous pulse; the pulse waits in pending.
                    pin_d     = desired_in;
                    counter_d = CNT_ONE;
                    state_d   = HOLD;
                    if (request_in) begin
                        if (pending_q) overrun_d = 1'b1;
                        else           pending_d = 1'b1;
                    end
                end else if (request_in || pending_q) begin
                    pin_d     = ~pin_q;
                    counter_d = CNT_ONE;
                    state_d   = PULSE;
                    // Serving the stored pulse while a new one arrives re-queues the new one.
                    pending_d = request_in && pending_q;
                end
            end

            HOLD: begin
                if (counter_q == HOLD_CNT) state_d   = IDLE;
                else                       counter_d = counter_inc;
                if (request_in) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
            end

            PULSE: begin
                if (counter_q == HOLD_CNT) begin
                    pin_d     = desired_in;
                    counter_d = CNT_ONE;
                    state_d   = HOLD;
                end else begin
                    counter_d = counter_inc;
                end
                if (request_in) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        posedge_d = pin_d & ~pin_q;
        negedge_d = ~pin_d & pin_q;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            pending_q <= 1'b0;
            pin_q     <= 1'b0;
            posedge_q <= 1'b0;
            negedge_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            pending_q <= pending_d;
            pin_q     <= pin_d;
            posedge_q <= posedge_d;
            negedge_q <= negedge_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.pin          = pin_q;
    assign bus.positiveedge = posedge_q;
    assign bus.negativeedge = negedge_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_output_conditioner.sv
// Directed bench for output_conditioner; each step checks {pin,positiveedge,negativeedge,busy,overrun}.
`timescale 1ns/1ps
module tb_output_conditioner;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    output_conditioner_if bus ();

    output_conditioner #(
        .counterwidth (3),
        .HOLDTIME     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [4:0] obs;
    assign obs = {bus.pin, bus.positiveedge, bus.negativeedge, bus.busy, bus.overrun};

    // Advance one clock, then compare the outputs 1 ns after the edge.
    task automatic step(input string tag, input logic [4:0] exp);
        @(posedge clk);
        #1;
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got pin/pe/ne/busy/ovr=%b expected=%b", tag, obs, exp);
        end
    endtask

`ifndef OUTCOND_SYNC_EN
    logic [4:0] hold_exp [10];
`endif

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.pulsereq = 1'b0;

`ifndef OUTCOND_SYNC_EN
        hold_exp = '{5'b00110, 5'b00010, 5'b00010, 5'b00000, 5'b00000,
                     5'b11010, 5'b10010, 5'b10010, 5'b10000, 5'b10000};

        // Reset with desired=1, then release: pin rises one clock later.
        bus.desired = 1'b1;
        step("rst0", 5'b00000);
        step("rst1", 5'b00000);
        reset = 1'b0;
        step("rel_rise", 5'b11010);
        step("rel_h1",   5'b10010);
        step("rel_h2",   5'b10010);
        step("rel_idle", 5'b10000);
        step("rel_stay", 5'b10000);

        // Toggle desired every clock; pin only follows after each hold expires.
        for (int k = 0; k < 10; k++) begin
            bus.desired = k[0];
            step($sformatf("minhold%0d", k), hold_exp[k]);
        end
        total++;
        assert (bus.pin === bus.desired) else begin
            bad++;
            $error("FAIL minhold_final: got pin=%b expected=%b", bus.pin, bus.desired);
        end

        bus.desired = 1'b0;
        step("lvl0_fall", 5'b00110);
        step("lvl0_h1",   5'b00010);
        step("lvl0_h2",   5'b00010);
        step("lvl0_idle", 5'b00000);

        // Single pulse from idle low.
        bus.pulsereq = 1'b1;
        step("pulse_rise", 5'b11010);
        bus.pulsereq = 1'b0;
        step("pulse_p2",   5'b10010);
        step("pulse_p3",   5'b10010);
        step("pulse_fall", 5'b00110);
        step("pulse_h2",   5'b00010);
        step("pulse_h3",   5'b00010);
        step("pulse_idle", 5'b00000);

        // Level change and pulse request on the same clock.
        bus.desired  = 1'b1;
        bus.pulsereq = 1'b1;
        step("col_rise",  5'b11010);
        bus.pulsereq = 1'b0;
        step("col_h2",    5'b10010);
        step("col_h3",    5'b10010);
        step("col_idle",  5'b10000);
        step("col_pfall", 5'b00110);
        step("col_p2",    5'b00010);
        step("col_p3",    5'b00010);
        step("col_prise", 5'b11010);
        step("col_ph2",   5'b10010);
        step("col_ph3",   5'b10010);
        step("col_done",  5'b10000);

        // Pulse plus three more strobes: one queued, two discarded.
        bus.pulsereq = 1'b1;
        step("ovr_fall1", 5'b00110);
        step("ovr_pend",  5'b00010);
        step("ovr_drop1", 5'b00011);
        step("ovr_drop2", 5'b11011);
        bus.pulsereq = 1'b0;
        step("ovr_h2",    5'b10010);
        step("ovr_h3",    5'b10010);
        step("ovr_idle",  5'b10000);
        step("ovr_fall2", 5'b00110);
        step("ovr_p2",    5'b00010);
        step("ovr_p3",    5'b00010);
        step("ovr_rise2", 5'b11010);
        step("ovr_ph2",   5'b10010);
        step("ovr_ph3",   5'b10010);
        step("ovr_done",  5'b10000);

        // Reset in the middle of a pulse forces pin low on that edge.
        bus.pulsereq = 1'b1;
        step("midrst_fall", 5'b00110);
        bus.pulsereq = 1'b0;
        reset = 1'b1;
        step("midrst_rst",  5'b00000);
        reset = 1'b0;
        step("midrst_rise", 5'b11010);
        step("midrst_h2",   5'b10010);
        step("midrst_h3",   5'b10010);
        step("midrst_idle", 5'b10000);
`else
        bus.desired = 1'b0;
        step("srst0", 5'b00000);
        step("srst1", 5'b00000);
        reset = 1'b0;
        step("sidle0", 5'b00000);
        step("sidle1", 5'b00000);

        // desired change reaches the pin on the third edge.
        bus.desired = 1'b1;
        step("slat1",  5'b00000);
        step("slat2",  5'b00000);
        step("srise",  5'b11010);
        step("sh2",    5'b10010);
        step("sh3",    5'b10010);
        step("sidle2", 5'b10000);

        // pulsereq held for 5 clocks yields exactly one pulse.
        bus.pulsereq = 1'b1;
        step("sreq1",  5'b10000);
        step("sreq2",  5'b10000);
        step("sfall",  5'b00110);
        step("sp2",    5'b00010);
        step("sp3",    5'b00010);
        bus.pulsereq = 1'b0;
        step("sprise", 5'b11010);
        step("sph2",   5'b10010);
        step("sph3",   5'b10010);
        step("sdone0", 5'b10000);
        step("sdone1", 5'b10000);
        step("sdone2", 5'b10000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
